csi2_csr_master: RTL

CSI2_CSR_MASTER -- requirements
Module: csi2_csr_master

---
 rtl/csi2_csr_pkg.sv | 15 +
 rtl/axi4_lite_if.sv | 37 +++
 rtl/csi2_csr_master.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/csi2_csr_pkg.sv
// Shared types for the CSI-2 CSR AXI4-Lite master: FSM state encoding and AXI response codes.
package csi2_csr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/csi2_csr_master.sv
// Single-outstanding AXI4-Lite master that turns CSR commands into bus transactions,
// with a per-phase watchdog that aborts a hung slave and reports SLVERR.
module csi2_csr_master
    import csi2_csr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_resp_o,
    output logic                    rsp_timeout_o,
    axi4_lite_if.master             csr_if
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    // Counter holds (cycles spent in phase - 1); this value marks the last allowed cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_cmd_ready;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic                  r_rsp_timeout;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_progress;
    logic w_abort;

    assign w_aw_hs  = r_awvalid & csr_if.awready;
    assign w_w_hs   = r_wvalid & csr_if.wready;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    // Phase completes this cycle; a completing phase always beats watchdog expiry.
    always_comb begin
        w_progress = 1'b0;
        case (r_state)
            WR_REQ:  w_progress = w_aw_fin & w_w_fin;
            WR_RESP: w_progress = csr_if.bvalid;
            RD_REQ:  w_progress = csr_if.arready;
            RD_RESP: w_progress = csr_if.rvalid;
            default: w_progress = 1'b0;
        endcase
    end

    assign w_abort = (r_state != IDLE) & ~w_progress & (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            if (w_abort) begin
                r_state       <= IDLE;
                r_cnt         <= '0;
                r_cmd_ready   <= 1'b1;
                r_aw_done     <= 1'b0;
                r_w_done      <= 1'b0;
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_timeout <= 1'b1;
                r_rsp_resp    <= RESP_SLVERR;
                r_rsp_rdata   <= '0;
            end else begin
                if (r_state != IDLE) begin
                    r_cnt <= w_progress ? '0 : r_cnt + CNT_W'(1);
                end
                case (r_state)
                    IDLE: begin
                        if (cmd_valid_i) begin
                            r_addr      <= cmd_addr_i;
                            r_wdata     <= cmd_wdata_i;
                            r_wstrb     <= cmd_wstrb_i;
                            r_cmd_ready <= 1'b0;
                            if (cmd_wr_i) begin
                                r_state   <= WR_REQ;
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                            end else begin
                                r_state   <= RD_REQ;
                                r_arvalid <= 1'b1;
                            end
                        end
                    end
                    WR_REQ: begin
                        if (w_aw_hs) r_awvalid <= 1'b0;
                        if (w_w_hs)  r_wvalid  <= 1'b0;
                        if (w_progress) begin
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_bready  <= 1'b1;
                            r_state   <= WR_RESP;
                        end else begin
                            r_aw_done <= w_aw_fin;
                            r_w_done  <= w_w_fin;
                        end
                    end
                    WR_RESP: begin
                        if (csr_if.bvalid) begin
                            r_bready    <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_resp  <= csr_if.bresp;
                            r_rsp_rdata <= '0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                    RD_REQ: begin
                        if (csr_if.arready) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_state   <= RD_RESP;
                        end
                    end
                    RD_RESP: begin
                        if (csr_if.rvalid) begin
                            r_rready    <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_resp  <= csr_if.rresp;
                            r_rsp_rdata <= csr_if.rdata;
                            r_cmd_ready <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cmd_ready_o    = r_cmd_ready;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_rdata_o    = r_rsp_rdata;
    assign rsp_resp_o     = r_rsp_resp;
    assign rsp_timeout_o  = r_rsp_timeout;

    assign csr_if.awvalid = r_awvalid;
    assign csr_if.awaddr  = r_addr;
    assign csr_if.awprot  = 3'b000;
    assign csr_if.wvalid  = r_wvalid;
    assign csr_if.wdata   = r_wdata;
    assign csr_if.wstrb   = r_wstrb;
    assign csr_if.bready  = r_bready;
    assign csr_if.arvalid = r_arvalid;
    assign csr_if.araddr  = r_addr;
    assign csr_if.arprot  = 3'b000;
    assign csr_if.rready  = r_rready;

endmodule
